// File: rtl/rvvi_trace_pkg.sv
// Shared types and helpers for the RVVI retirement trace collector.
// Records are carried at the maximum PC width. Narrower harts zero-extend
// the PC, so one FIFO type serves every XLEN.
package rvvi_trace_pkg;

   localparam int XLEN_MAX = 64;
   localparam int ILEN     = 32;
   localparam int ORDW     = 64;
   localparam int MAX_HART = 8;

   typedef struct packed {
      logic [ORDW-1:0]     order;
      logic [XLEN_MAX-1:0] pc;
      logic [ILEN-1:0]     insn;
      logic                trap;
   } trace_rec_t;

   // Returns the first requesting index at or after ptr, wrapping modulo n.
   // If nothing requests, ptr is returned unchanged.
   function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                          input logic [7:0] req,
                                          input int unsigned n);
      logic [2:0]  res;
      logic        found;
      int unsigned idx;
      res   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= n) begin
            idx = idx - n;
         end else begin
            idx = idx;
         end
         if ((i < n) && !found && req[idx[2:0]]) begin
            res   = idx[2:0];
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Single-hart synchronous FIFO of trace records.
// A push is accepted when the FIFO is not full, or when it is full and a
// pop happens in the same cycle. The head is read straight from storage,
// so there is no combinational path from the write port to the head.
module rvvi_trace_fifo
   import rvvi_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  trace_rec_t wr_rec,
   output logic       full,
   output logic       empty,
   output trace_rec_t head
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   trace_rec_t  mem [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        do_push_s;
   logic        do_pop_s;

   // Status flags, accepted push/pop, and the head record.
   always_comb begin
      empty     = (wr_ptr_r == rd_ptr_r);
      full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      head      = mem[rd_ptr_r[AW-1:0]];
   end

   // Read/write pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Record storage. It needs no reset because empty entries are never
   // presented as valid.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem[wr_ptr_r[AW-1:0]] <= wr_rec;
      end
   end

endmodule

// File: rtl/rvvi_trace_collector.sv
// Multi-hart RVVI retirement trace collector.
// Each hart's records go into a private FIFO. The FIFOs are merged
// round-robin into one valid/ready stream. A hart whose FIFO is full loses
// the record, and this is counted in its overflow statistics.
// Optional build macro RVVI_TRACE_ORDER_CHECK_EN adds per-hart order-number
// continuity checking and the order_err output.
module rvvi_trace_collector
   import rvvi_trace_pkg::*;
#(
   parameter  int NHART = 2,
   parameter  int XLEN  = 64,
   parameter  int DEPTH = 8,
   parameter  int CNTW  = 16,
   localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NHART-1:0]      ret_valid,
   input  logic [NHART*64-1:0]   ret_order,
   input  logic [NHART*XLEN-1:0] ret_pc,
   input  logic [NHART*32-1:0]   ret_insn,
   input  logic [NHART-1:0]      ret_trap,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [HW-1:0]         out_hart,
   output logic [63:0]           out_order,
   output logic [XLEN-1:0]       out_pc,
   output logic [31:0]           out_insn,
   output logic                  out_trap,
   output logic [NHART-1:0]      ovf_sticky,
   output logic [NHART*CNTW-1:0] drop_cnt,
   input  logic                  clr_stats
`ifdef RVVI_TRACE_ORDER_CHECK_EN
   ,
   output logic [NHART-1:0]      order_err
`endif
);

   localparam logic [HW-1:0]   LAST_HART = HW'(NHART - 1);
   localparam logic [HW-1:0]   HART_ONE  = HW'(1);
   localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

   logic [NHART-1:0]      full_s;
   logic [NHART-1:0]      empty_s;
   logic [NHART-1:0]      pop_s;
   logic [NHART-1:0]      push_s;
   logic [NHART-1:0]      drop_s;
   trace_rec_t            head_s   [NHART];
   trace_rec_t            wr_rec_s [NHART];
   logic [7:0]            req_s;
   logic                  any_s;
   logic                  hs_s;
   logic [HW-1:0]         grant_s;
   trace_rec_t            out_rec_s;
   logic [HW-1:0]         grant_r;
   logic [HW-1:0]         rr_ptr_r;
   logic                  lock_r;
   logic [NHART-1:0]      ovf_sticky_r;
   logic [NHART*CNTW-1:0] drop_cnt_r;

   // One FIFO per hart, fed by that hart's retire slice.
   for (genvar g = 0; g < NHART; g++) begin : g_hart
      assign wr_rec_s[g] = '{order: ret_order[g*64 +: 64],
                             pc:    64'(ret_pc[g*XLEN +: XLEN]),
                             insn:  ret_insn[g*32 +: 32],
                             trap:  ret_trap[g]};

      rvvi_trace_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .push   (push_s[g]),
         .pop    (pop_s[g]),
         .wr_rec (wr_rec_s[g]),
         .full   (full_s[g]),
         .empty  (empty_s[g]),
         .head   (head_s[g])
      );
   end

   // Grant selection (held while locked), handshake, and per-hart push/pop/drop.
   always_comb begin
      req_s              = 8'd0;
      req_s[NHART-1:0]   = ~empty_s;
      any_s              = |(~empty_s);
      if (lock_r) begin
         grant_s = grant_r;
      end else begin
         grant_s = HW'(rr_next(3'(rr_ptr_r), req_s, NHART));
      end
      hs_s      = any_s && out_ready;
      out_rec_s = head_s[grant_s];
      pop_s     = '0;
      push_s    = '0;
      drop_s    = '0;
      for (int h = 0; h < NHART; h++) begin
         pop_s[h]  = hs_s && (grant_s == HW'(h));
         push_s[h] = ret_valid[h] && (!full_s[h] || pop_s[h]);
         drop_s[h] = ret_valid[h] && full_s[h] && !pop_s[h];
      end
   end

   // Arbitration state: the round-robin pointer advances past the served
   // hart on each handshake. The lock freezes the grant while the sampler
   // stalls a presented record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
         grant_r  <= '0;
         lock_r   <= 1'b0;
      end else begin
         grant_r <= grant_s;
         lock_r  <= any_s && !out_ready;
         if (hs_s) begin
            rr_ptr_r <= (grant_s == LAST_HART) ? '0 : (grant_s + HART_ONE);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Overflow statistics. A drop in the same cycle as a clear wins, so the
   // counter restarts at one instead of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_r <= '0;
         drop_cnt_r   <= '0;
      end else begin
         for (int h = 0; h < NHART; h++) begin
            if (drop_s[h]) begin
               ovf_sticky_r[h] <= 1'b1;
               if (clr_stats) begin
                  drop_cnt_r[h*CNTW +: CNTW] <= CNT_ONE;
               end else if (drop_cnt_r[h*CNTW +: CNTW] != CNT_MAX) begin
                  drop_cnt_r[h*CNTW +: CNTW] <= drop_cnt_r[h*CNTW +: CNTW] + CNT_ONE;
               end else begin
                  drop_cnt_r[h*CNTW +: CNTW] <= CNT_MAX;
               end
            end else if (clr_stats) begin
               ovf_sticky_r[h]            <= 1'b0;
               drop_cnt_r[h*CNTW +: CNTW] <= '0;
            end else begin
               ovf_sticky_r[h] <= ovf_sticky_r[h];
            end
         end
      end
   end

`ifdef RVVI_TRACE_ORDER_CHECK_EN
   logic [NHART-1:0][63:0] last_order_r;
   logic [NHART-1:0]       seen_r;
   logic [NHART-1:0]       order_err_r;

   // Order continuity: every retire strobe, including dropped ones, moves
   // the expected order forward. Only accepted pushes can flag an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_order_r <= '0;
         seen_r       <= '0;
         order_err_r  <= '0;
      end else begin
         for (int h = 0; h < NHART; h++) begin
            if (ret_valid[h]) begin
               last_order_r[h] <= ret_order[h*64 +: 64];
               seen_r[h]       <= 1'b1;
            end
            if (push_s[h] && seen_r[h] &&
                (ret_order[h*64 +: 64] != (last_order_r[h] + 64'd1))) begin
               order_err_r[h] <= 1'b1;
            end else if (clr_stats) begin
               order_err_r[h] <= 1'b0;
            end else begin
               order_err_r[h] <= order_err_r[h];
            end
         end
      end
   end

   assign order_err = order_err_r;
`endif

   // The merged stream reads from FIFO storage only. Data is zeroed while
   // no record is presented.
   assign out_valid  = any_s;
   assign out_hart   = any_s ? grant_s               : {HW{1'b0}};
   assign out_order  = any_s ? out_rec_s.order       : 64'd0;
   assign out_pc     = any_s ? out_rec_s.pc[XLEN-1:0] : {XLEN{1'b0}};
   assign out_insn   = any_s ? out_rec_s.insn        : 32'd0;
   assign out_trap   = any_s ? out_rec_s.trap        : 1'b0;
   assign ovf_sticky = ovf_sticky_r;
   assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_rvvi_trace_collector.sv
// Directed self-checking bench for rvvi_trace_collector (NHART=2, DEPTH=4).
// Define RVVI_TRACE_ORDER_CHECK_EN to also exercise order_err.
module tb_rvvi_trace_collector;

   logic         clk;
   logic         rst_n;
   logic [1:0]   ret_valid;
   logic [127:0] ret_order;
   logic [127:0] ret_pc;
   logic [63:0]  ret_insn;
   logic [1:0]   ret_trap;
   logic         out_valid;
   logic         out_ready;
   logic [0:0]   out_hart;
   logic [63:0]  out_order;
   logic [63:0]  out_pc;
   logic [31:0]  out_insn;
   logic         out_trap;
   logic [1:0]   ovf_sticky;
   logic [31:0]  drop_cnt;
   logic         clr_stats;
`ifdef RVVI_TRACE_ORDER_CHECK_EN
   logic [1:0]   order_err;
`endif

   int checks = 0;
   int errors = 0;

   rvvi_trace_collector #(
      .NHART (2),
      .XLEN  (64),
      .DEPTH (4),
      .CNTW  (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ret_valid  (ret_valid),
      .ret_order  (ret_order),
      .ret_pc     (ret_pc),
      .ret_insn   (ret_insn),
      .ret_trap   (ret_trap),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_hart   (out_hart),
      .out_order  (out_order),
      .out_pc     (out_pc),
      .out_insn   (out_insn),
      .out_trap   (out_trap),
      .ovf_sticky (ovf_sticky),
      .drop_cnt   (drop_cnt),
      .clr_stats  (clr_stats)
`ifdef RVVI_TRACE_ORDER_CHECK_EN
      ,
      .order_err  (order_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pc = 0x8000_0000 + 4*order, insn = 0x13 + order, trap = order[0]
   task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
      ret_valid = v;
      ret_order = {o1, o0};
      ret_pc    = {64'h8000_0000 + (o1 << 2), 64'h8000_0000 + (o0 << 2)};
      ret_insn  = {32'h13 + o1[31:0], 32'h13 + o0[31:0]};
      ret_trap  = {o1[0], o0[0]};
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      drive(2'b00, 64'd0, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
      checks++; if (ovf_sticky !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", ovf_sticky); end
      checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", drop_cnt); end
      checks++; if (out_order !== 64'd0) begin errors++; $display("FAIL reset_order got %0d exp 0", out_order); end
      // Reset asserted mid-stream discards buffered records.
      drive(2'b01, 64'd50, 64'd0);
      tick();
      drive(2'b01, 64'd51, 64'd0);
      tick();
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %0b exp 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got %0b exp 0", out_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got %0b exp 0", out_valid); end
   endtask

   task automatic test_single_hart();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 64'(10 + i), 64'd0);
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %0b exp 1", i, out_valid); end
         checks++; if (out_order !== 64'(10 + i)) begin errors++; $display("FAIL single_order[%0d] got %0d exp %0d", i, out_order, 10 + i); end
         checks++; if (out_hart !== 1'b0) begin errors++; $display("FAIL single_hart[%0d] got %0d exp 0", i, out_hart); end
         checks++; if (out_pc !== 64'h8000_0000 + 64'(4 * (10 + i))) begin errors++; $display("FAIL single_pc[%0d] got %h", i, out_pc); end
         checks++; if (out_insn !== 32'(32'h13 + 10 + i)) begin errors++; $display("FAIL single_insn[%0d] got %h", i, out_insn); end
         checks++; if (out_trap !== i[0]) begin errors++; $display("FAIL single_trap[%0d] got %0b exp %0b", i, out_trap, i[0]); end
      end
      drive(2'b00, 64'd0, 64'd0);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0b exp 0", out_valid); end
      checks++; if (out_order !== 64'd0) begin errors++; $display("FAIL single_drain_order got %0d exp 0", out_order); end
   endtask

   task automatic test_alternate();
      logic [63:0] exp_order;
      logic        exp_hart;
      do_reset();
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k <= 4) begin
            drive(2'b11, 64'(100 + k - 1), 64'(200 + k - 1));
         end else begin
            drive(2'b00, 64'd0, 64'd0);
         end
         tick();
         exp_hart  = (k % 2 == 1) ? 1'b0 : 1'b1;
         exp_order = (k % 2 == 1) ? 64'(100 + (k - 1) / 2) : 64'(200 + k / 2 - 1);
         checks++; if (out_hart !== exp_hart) begin errors++; $display("FAIL alt_hart[%0d] got %0d exp %0d", k, out_hart, exp_hart); end
         checks++; if (out_order !== exp_order) begin errors++; $display("FAIL alt_order[%0d] got %0d exp %0d", k, out_order, exp_order); end
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alt_drain got %0b exp 0", out_valid); end
      checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL alt_drops got %h exp 0", drop_cnt); end
      checks++; if (ovf_sticky !== 2'b00) begin errors++; $display("FAIL alt_sticky got %b exp 00", ovf_sticky); end
   endtask

   task automatic test_overflow();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(2'b10, 64'd0, 64'(300 + i));
         tick();
      end
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (drop_cnt[31:16] !== 16'd2) begin errors++; $display("FAIL ovf_cnt1 got %0d exp 2", drop_cnt[31:16]); end
      checks++; if (drop_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL ovf_cnt0 got %0d exp 0", drop_cnt[15:0]); end
      checks++; if (ovf_sticky !== 2'b10) begin errors++; $display("FAIL ovf_sticky got %b exp 10", ovf_sticky); end
      checks++; if (out_hart !== 1'b1) begin errors++; $display("FAIL ovf_hart got %0d exp 1", out_hart); end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++; if (out_valid !== (i < 4)) begin errors++; $display("FAIL ovf_drain_valid[%0d] got %0b exp %0b", i, out_valid, (i < 4)); end
         if (i < 4) begin
            checks++; if (out_order !== 64'(300 + i)) begin errors++; $display("FAIL ovf_drain_order[%0d] got %0d exp %0d", i, out_order, 300 + i); end
         end
         tick();
      end
   endtask

   task automatic test_lock();
      do_reset();
      out_ready = 1'b1;
      drive(2'b01, 64'd399, 64'd0);
      tick();
      drive(2'b00, 64'd0, 64'd0);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_pre_valid got %0b exp 0", out_valid); end
      out_ready = 1'b0;
      drive(2'b01, 64'd400, 64'd0);
      tick();
      checks++; if (out_order !== 64'd400) begin errors++; $display("FAIL lock_first_order got %0d exp 400", out_order); end
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, 64'd0, 64'(500 + i));
         tick();
         checks++; if (out_hart !== 1'b0) begin errors++; $display("FAIL lock_hart[%0d] got %0d exp 0", i, out_hart); end
         checks++; if (out_order !== 64'd400) begin errors++; $display("FAIL lock_order[%0d] got %0d exp 400", i, out_order); end
         checks++; if (out_pc !== 64'h8000_0640) begin errors++; $display("FAIL lock_pc[%0d] got %h exp 80000640", i, out_pc); end
      end
      drive(2'b00, 64'd0, 64'd0);
      out_ready = 1'b1;
      tick();
      checks++; if (out_hart !== 1'b1) begin errors++; $display("FAIL lock_next_hart got %0d exp 1", out_hart); end
      checks++; if (out_order !== 64'd500) begin errors++; $display("FAIL lock_next_order got %0d exp 500", out_order); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, 64'(600 + i), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      drive(2'b01, 64'd604, 64'd0);
      tick();
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL fpp_cnt got %h exp 0", drop_cnt); end
      checks++; if (ovf_sticky !== 2'b00) begin errors++; $display("FAIL fpp_sticky got %b exp 00", ovf_sticky); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== (i < 4)) begin errors++; $display("FAIL fpp_valid[%0d] got %0b exp %0b", i, out_valid, (i < 4)); end
         if (i < 4) begin
            checks++; if (out_order !== 64'(601 + i)) begin errors++; $display("FAIL fpp_order[%0d] got %0d exp %0d", i, out_order, 601 + i); end
         end
         tick();
      end
   endtask

   task automatic test_clr_stats();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(2'b10, 64'd0, 64'(700 + i));
         tick();
      end
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (drop_cnt[31:16] !== 16'd1) begin errors++; $display("FAIL clr_pre_cnt got %0d exp 1", drop_cnt[31:16]); end
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL clr_cnt got %h exp 0", drop_cnt); end
      checks++; if (ovf_sticky !== 2'b00) begin errors++; $display("FAIL clr_sticky got %b exp 00", ovf_sticky); end
      drive(2'b10, 64'd0, 64'd705);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      checks++; if (ovf_sticky !== 2'b10) begin errors++; $display("FAIL clr_race_sticky got %b exp 10", ovf_sticky); end
      checks++; if (drop_cnt[31:16] !== 16'd1) begin errors++; $display("FAIL clr_race_cnt got %0d exp 1", drop_cnt[31:16]); end
      drive(2'b10, 64'd0, 64'd706);
      tick();
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (drop_cnt[31:16] !== 16'd2) begin errors++; $display("FAIL clr_after_cnt got %0d exp 2", drop_cnt[31:16]); end
   endtask

`ifdef RVVI_TRACE_ORDER_CHECK_EN
   task automatic test_order_check();
      do_reset();
      out_ready = 1'b1;
      drive(2'b01, 64'd5, 64'd0);
      tick();
      checks++; if (order_err !== 2'b00) begin errors++; $display("FAIL ord_first got %b exp 00", order_err); end
      drive(2'b01, 64'd6, 64'd0);
      tick();
      checks++; if (order_err !== 2'b00) begin errors++; $display("FAIL ord_seq got %b exp 00", order_err); end
      drive(2'b01, 64'd8, 64'd0);
      tick();
      drive(2'b00, 64'd0, 64'd0);
      checks++; if (order_err !== 2'b01) begin errors++; $display("FAIL ord_gap got %b exp 01", order_err); end
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      checks++; if (order_err !== 2'b00) begin errors++; $display("FAIL ord_clr got %b exp 00", order_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_hart();
      test_alternate();
      test_overflow();
      test_lock();
      test_full_push_pop();
      test_clr_stats();
`ifdef RVVI_TRACE_ORDER_CHECK_EN
      test_order_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
